// File: rtl/key_conditioner.sv
// Push-button conditioner: two-flop synchroniser, debouncer, edge pulses and an
// auto-repeating STEP generator, one independent lane per key.
module key_conditioner #(
  parameter int N_KEYS          = 3,
  parameter int CNT_W           = 26,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] KEY_LEVEL,
  output logic [N_KEYS-1:0] KEY_PRESS,
  output logic [N_KEYS-1:0] KEY_RELEASE,
  output logic [N_KEYS-1:0] KEY_STEP
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rp_state_e;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [N_KEYS-1:0]            sync1_q, sync2_q;
  logic [N_KEYS-1:0]            level_q, level_d;
  logic [N_KEYS-1:0]            press_q, press_d;
  logic [N_KEYS-1:0]            release_q, release_d;
  logic [N_KEYS-1:0]            step_q, step_d;
  logic [N_KEYS-1:0][CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [N_KEYS-1:0][CNT_W-1:0] rp_cnt_q, rp_cnt_d;
  rp_state_e                    state_q [N_KEYS];
  rp_state_e                    state_d [N_KEYS];

  // Per-lane debounce, edge detection and repeat FSM next-state logic.
  // Rise/fall are taken from level_d so PRESS/STEP/RELEASE land on the same edge
  // as KEY_LEVEL, and a falling level suppresses a coincident terminal-count STEP.
  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      level_d[i]  = level_q[i];
      db_cnt_d[i] = db_cnt_q[i];
      state_d[i]  = state_q[i];
      rp_cnt_d[i] = rp_cnt_q[i];
      step_d[i]   = 1'b0;

      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i]  = ~level_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CNT_ONE;
        end
      end else begin
        db_cnt_d[i] = '0;
      end

      press_d[i]   = level_d[i] & ~level_q[i];
      release_d[i] = ~level_d[i] & level_q[i];

      case (state_q[i])
        ST_IDLE: begin
          if (press_d[i]) begin
            step_d[i]  = 1'b1;
            rp_cnt_d[i] = '0;
            state_d[i] = ST_DELAY;
          end else begin
            rp_cnt_d[i] = '0;
          end
        end
        ST_DELAY: begin
          if (release_d[i]) begin
            rp_cnt_d[i] = '0;
            state_d[i]  = ST_IDLE;
          end else if (rp_cnt_q[i] == RD_LAST) begin
            step_d[i]   = 1'b1;
            rp_cnt_d[i] = '0;
            state_d[i]  = ST_REPEAT;
          end else begin
            rp_cnt_d[i] = rp_cnt_q[i] + CNT_ONE;
          end
        end
        ST_REPEAT: begin
          if (release_d[i]) begin
            rp_cnt_d[i] = '0;
            state_d[i]  = ST_IDLE;
          end else if (rp_cnt_q[i] == RR_LAST) begin
            step_d[i]   = 1'b1;
            rp_cnt_d[i] = '0;
          end else begin
            rp_cnt_d[i] = rp_cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          rp_cnt_d[i] = '0;
          state_d[i]  = ST_IDLE;
        end
      endcase
    end
  end

  // State registers; the synchroniser inverts so that 1 means pressed.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      step_q    <= '0;
      db_cnt_q  <= '0;
      rp_cnt_q  <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        state_q[i] <= ST_IDLE;
      end
    end else begin
      sync1_q   <= ~KEY;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      step_q    <= step_d;
      db_cnt_q  <= db_cnt_d;
      rp_cnt_q  <= rp_cnt_d;
      state_q   <= state_d;
    end
  end

  assign KEY_LEVEL   = level_q;
  assign KEY_PRESS   = press_q;
  assign KEY_RELEASE = release_q;
  assign KEY_STEP    = step_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner with short debounce/repeat timings.
module tb_key_conditioner;

  localparam int N   = 3;
  localparam int DB  = 4;
  localparam int RD  = 10;
  localparam int RR  = 3;
  localparam int LAT = DB + 2;
  localparam int NONE = 9999;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] key = 3'b111;
  logic [N-1:0] lvl, prs, rel, stp;

  always #5 clk = ~clk;

  key_conditioner #(
    .N_KEYS(N), .CNT_W(8), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .CLOCK_50(clk), .RESET(rst), .KEY(key),
    .KEY_LEVEL(lvl), .KEY_PRESS(prs), .KEY_RELEASE(rel), .KEY_STEP(stp)
  );

  typedef struct {
    string      tag;
    int         cyc;
    logic [2:0] lvl, prs, rel, stp;
  } exp_t;

  typedef struct {
    string      name;
    logic [2:0] mask;
    int         hold;
    int         press;
    int         release_at;
    int         ncyc;
  } vec_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // STEP schedule while held: press, press+RD, then every RR; none at or after release.
  function automatic bit is_step(int e, int p, int r);
    if (e < p || e >= r) return 1'b0;
    if (e == p) return 1'b1;
    if (e < p + RD) return 1'b0;
    return ((e - p - RD) % RR) == 0;
  endfunction

  function automatic exp_t hold_exp(string tag, int cyc, logic [2:0] m, int e, int p, int r);
    exp_t x;
    x.tag = tag;
    x.cyc = cyc;
    x.lvl = (e >= p && e < r) ? m : 3'b000;
    x.prs = (e == p) ? m : 3'b000;
    x.rel = (e == r) ? m : 3'b000;
    x.stp = is_step(e, p, r) ? m : 3'b000;
    return x;
  endfunction

  function automatic exp_t zero_exp(string tag, int cyc);
    exp_t x;
    x.tag = tag;
    x.cyc = cyc;
    x.lvl = 3'b000;
    x.prs = 3'b000;
    x.rel = 3'b000;
    x.stp = 3'b000;
    return x;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if ({lvl, prs, rel, stp} !== {e.lvl, e.prs, e.rel, e.stp}) begin
        errors++;
        $display("FAIL %s cyc=%0d: got lvl=%b prs=%b rel=%b stp=%b, want lvl=%b prs=%b rel=%b stp=%b",
                 e.tag, e.cyc, lvl, prs, rel, stp, e.lvl, e.prs, e.rel, e.stp);
      end
    end
  end

  task automatic cyc(input logic [2:0] k, input logic r, input exp_t e);
    key = k;
    rst = r;
    sb_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{"all_keys_after_reset", 3'b111, 12, LAT, 18, 22};
    vecs[1] = '{"autorepeat_k2",        3'b100, 40, LAT, 46, 50};
    vecs[2] = '{"release_k0",           3'b001, 14, LAT, 20, 24};
    vecs[3] = '{"release_on_step_k0",   3'b001, 16, LAT, 22, 26};
    vecs[4] = '{"simultaneous_k1k2",    3'b110, 20, LAT, 26, 30};
    vecs[5] = '{"short_hold_k1",        3'b010,  5, LAT, 11, 15};
    vecs[6] = '{"min_hold_k1",          3'b010,  4, LAT, 10, 14};
    vecs[7] = '{"glitch_db_minus1_k0",  3'b001,  3, NONE, NONE, 12};

    @(negedge clk);
    #1;

    for (int i = 0; i < 2; i++) begin
      cyc(3'b000, 1'b1, zero_exp("reset_state", i));
    end

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < vecs[v].ncyc; i++) begin
        cyc((i < vecs[v].hold) ? ~vecs[v].mask : 3'b111, 1'b0,
            hold_exp(vecs[v].name, i + 1, vecs[v].mask, i + 1, vecs[v].press, vecs[v].release_at));
      end
    end

    // Bouncing: 3 cycles pressed, 1 released, five times, then a clean hold to cycle 30.
    for (int i = 0; i < 40; i++) begin
      logic pressed;
      if (i < 20) pressed = ((i % 4) != 3);
      else        pressed = (i < 30);
      cyc(pressed ? 3'b101 : 3'b111, 1'b0,
          hold_exp("bounce_k1", i + 1, 3'b010, i + 1, 20 + LAT, 30 + LAT));
    end

    // Reset pulse on edge 18 during a hold of KEY[2]; lane re-debounces afterwards.
    for (int i = 0; i < 50; i++) begin
      exp_t e;
      if (i + 1 < 18)       e = hold_exp("reset_mid_hold_pre", i + 1, 3'b100, i + 1, LAT, NONE);
      else if (i + 1 == 18) e = zero_exp("reset_mid_hold_rst", i + 1);
      else                  e = hold_exp("reset_mid_hold_post", i + 1, 3'b100, i + 1 - 18, LAT, 40 - 18 + LAT);
      cyc((i < 40) ? 3'b011 : 3'b111, (i == 17) ? 1'b1 : 1'b0, e);
    end

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
